// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode-side request, ALU-side operand output and sticky error flag.
// The master drives requests and out_ready; the slave is the issue stage.
interface alu_issue_if #(
  parameter int N = 32,
  parameter int M = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] rs_data;
  logic [N-1:0] rt_data;
  logic [N-1:0] imm;
  logic [M-1:0] shamt;
  logic         alu_src;
  logic         shift_src;
  logic [3:0]   alu_op;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   OP;
  logic         op_err;

  modport master (
    output in_valid, rs_data, rt_data, imm, shamt, alu_src, shift_src, alu_op,
           flush, out_ready,
    input  in_ready, out_valid, A, B, OP, op_err
  );

  modport slave (
    input  in_valid, rs_data, rt_data, imm, shamt, alu_src, shift_src, alu_op,
           flush, out_ready,
    output in_ready, out_valid, A, B, OP, op_err
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: selects operand B, screens the opcode and registers the operation
// into a two-entry (output + skid) buffer with a registered in_ready.
package global_pkg;
  localparam int N = 32;
  localparam int M = 5;
endpackage

// state    | meaning
// ST_EMPTY | no operation held; out_valid=0, in_ready=1
// ST_HOLD  | output register valid, skid empty; in_ready=1
// ST_FULL  | output and skid both valid; in_ready=0
module alu_issue_stage #(
  parameter int N = global_pkg::N,
  parameter int M = global_pkg::M
) (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, b_q, a_skid_q, b_skid_q;
  logic [3:0]   op_q, op_skid_q;
  logic         op_err_q;

  logic         in_ready, out_valid;
  logic         take, xfer;
  logic         load_out_new, load_out_skid, load_skid;
  logic         op_legal;
  logic [N-1:0] b_sel, a_in, b_in;
  logic [3:0]   op_in;

  always_comb begin
    op_legal = 1'b0;
    case (bus.alu_op)
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110,
      4'b0100, 4'b0101, 4'b0110: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    if (bus.shift_src)
      b_sel = {{(N-M){1'b0}}, bus.shamt};
    else if (bus.alu_src)
      b_sel = bus.imm;
    else
      b_sel = bus.rt_data;
  end

  // Illegal opcodes become a harmless 0100 with zeroed operands.
  assign a_in  = op_legal ? bus.rs_data : '0;
  assign b_in  = op_legal ? b_sel : '0;
  assign op_in = op_legal ? bus.alu_op : 4'b0100;

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign take      = bus.in_valid & in_ready & ~bus.flush;
  assign xfer      = out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (take) begin
            load_out_new = 1'b1;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (take && xfer) begin
            load_out_new = 1'b1;
          end else if (take) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            load_out_skid = 1'b1;
            state_d       = ST_HOLD;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 4'b0000;
      a_skid_q  <= '0;
      b_skid_q  <= '0;
      op_skid_q <= 4'b0000;
    end else begin
      if (load_out_new) begin
        a_q  <= a_in;
        b_q  <= b_in;
        op_q <= op_in;
      end else if (load_out_skid) begin
        a_q  <= a_skid_q;
        b_q  <= b_skid_q;
        op_q <= op_skid_q;
      end
      if (load_skid) begin
        a_skid_q  <= a_in;
        b_skid_q  <= b_in;
        op_skid_q <= op_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_err_q <= 1'b0;
    else if (take && !op_legal)
      op_err_q <= 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.OP        = op_q;
  assign bus.op_err    = op_err_q;

endmodule
